duty_ramp_gen: RTL and testbench
================================

// Module: duty_ramp_gen
// PURPOSE
//  Triangle-wave duty generator that feeds the pwm stage's pwm_value input.
//  Ramps the duty linearly from 0 to peak, then back to 0, repeating.
//  Emits a one-cycle phase_tick at every peak and every trough.
//  The colour-phase sequencer uses phase_tick to advance its phase, so colour changes stay locked to the fade.
// PARAMETERS
//  PWM_INTERVAL  1800   pwm period in clocks; pwm_value is $clog2(PWM_INTERVAL) bits wide
//  STEPS         200    duty steps per half-ramp (>=2, <=PWM_INTERVAL)
//  STEP_CYCLES   10000  clocks per duty step (>=1); half-ramp = STEPS*STEP_CYCLES clocks
//  HOLD_STEPS    50     dwell length at peak/trough, in step periods (used only with DUTY_RAMP_HOLD_EN)
// PORTS
//  clk         in   1                       system clock
//  rst_n       in   1                       reset, asynchronous, active-low
//  enable      in   1                       1 = run the ramp; 0 = park at duty 0
//  sync        in   1                       one-cycle pulse: restart the ramp at duty 0, rising
//  pwm_value   out  $clog2(PWM_INTERVAL)    registered duty value for the pwm stage
//  dir_down    out  1                       1 while falling (or holding at peak)
//  phase_tick  out  1                       one-cycle pulse at each peak and trough
// BEHAVIOUR
//  Constants: STEP_SIZE = PWM_INTERVAL/STEPS (integer division); PEAK = STEPS*STEP_SIZE <= PWM_INTERVAL.
//  Reset (rst_n=0, async):
//   - state=IDLE; pwm_value=0, dir_down=0, phase_tick=0.
//   - step_idx=0, prescaler=0.
//  States: IDLE, RISE, FALL (+HOLD_HI, HOLD_LO when DUTY_RAMP_HOLD_EN is defined).
//  IDLE:
//   - pwm_value=0, counters held at 0.
//   - enable=1 -> RISE on the next edge; prescaler starts at 0.
//  Prescaler:
//   - counts 0..STEP_CYCLES-1 in the run states.
//   - its terminal cycle is the "step strobe".
//   - wraps to 0 on the step strobe and on every state change.
//  RISE:
//   - on each step strobe, step_idx+1; pwm_value = (step_idx+1)*STEP_SIZE, registered on the same edge.
//   - when step_idx reaches STEPS, on that edge: pwm_value=PEAK, phase_tick=1 for one cycle, state -> FALL.
//  FALL:
//   - mirror of RISE: step_idx-1 per strobe.
//   - when step_idx reaches 0: pwm_value=0, phase_tick=1, state -> RISE.
//  Timing:
//   - pwm_value changes exactly once per STEP_CYCLES clocks.
//   - ticks are exactly STEPS*STEP_CYCLES clocks apart.
//   - the first tick comes STEPS*STEP_CYCLES+1 clocks after enable rises (the +1 is the IDLE exit).
//  Priority per cycle: enable=0 > sync > normal stepping.
//   - enable=0 in any state -> IDLE on the next edge; pwm_value=0; no phase_tick.
//   - sync=1 (with enable=1) -> RISE with step_idx=0, prescaler=0, pwm_value=0; no phase_tick.
//   - sync coinciding with a step strobe or peak: sync wins and the tick is suppressed.
//  Arithmetic: the multiply is by a constant; it may be replaced by a running add/subtract of STEP_SIZE.
//   The result must never exceed PEAK or go below 0.
//  Mid-operation reset: async clear to the reset values; stepping resumes only through IDLE.
// CONFIGURATION
//  DUTY_RAMP_HOLD_EN defined:
//   - after the peak tick: HOLD_HI for HOLD_STEPS step periods (pwm_value=PEAK, dir_down=1), then FALL.
//   - after the trough tick: HOLD_LO likewise (pwm_value=0, dir_down=0), then RISE.
//   - tick spacing becomes (STEPS+HOLD_STEPS)*STEP_CYCLES.
//   - enable and sync priority are unchanged in the hold states.
//  Not defined: no hold states; peak and trough last exactly one step period; HOLD_STEPS is ignored.
// STRUCTURE
//  Package duty_ramp_pkg:
//   - state enum typedef ramp_state_t.
//   - localparam functions step_size(PWM_INTERVAL,STEPS) and peak(...).
//  Sub-module step_prescaler:
//   - parameterised terminal-count counter with clear input and strobe output.
//   - serves both the step timing and the hold-period counting.
// TESTING (PWM_INTERVAL=100, STEPS=10, STEP_CYCLES=4 -> STEP_SIZE=10, PEAK=100)
//  1. rst_n=0 then 1, enable=0 for 20 clks -> pwm_value=0, phase_tick never 1.
//  2. enable=1 -> pwm_value sequence 0,10,...,100, changing every 4 clks.
//     - phase_tick at clock 41 after enable, then every 40 clks.
//     - dir_down toggles at each tick.
//  3. sync pulse while pwm_value=60 rising -> next cycle pwm_value=0, dir_down=0, no tick.
//     - then 10 after 4 clks.
//  4. enable=0 while FALL at 70 -> next cycle pwm_value=0, state IDLE.
//     - re-enable -> ramp restarts rising from 0.
//  5. rst_n pulsed low mid-ramp (async, between edges) -> outputs 0 immediately.
//  6. With DUTY_RAMP_HOLD_EN, HOLD_STEPS=2:
//     - pwm_value=100 for 12 clks at the peak; tick spacing 48 clks.
//     - sync during HOLD_HI -> restart at 0.

Source files
------------

// File: rtl/duty_ramp_pkg.sv
// Shared types and constant helpers for the triangle-wave duty generator.
// Optional build macro used by the generator: DUTY_RAMP_HOLD_EN (dwell at peak/trough).
package duty_ramp_pkg;

  // Ramp controller states; the hold states are only reachable with DUTY_RAMP_HOLD_EN.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_FALL    = 3'd2,
    ST_HOLD_HI = 3'd3,
    ST_HOLD_LO = 3'd4
  } ramp_state_t;

  // Duty increment per step (integer division, so the peak may sit below the interval).
  function automatic int unsigned step_size(input int unsigned pwm_interval,
                                            input int unsigned steps);
    return pwm_interval / steps;
  endfunction

  // Duty value reached at the top of the ramp.
  function automatic int unsigned peak(input int unsigned pwm_interval,
                                       input int unsigned steps);
    return steps * step_size(pwm_interval, steps);
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Terminal-count counter: counts 0..TERMINAL-1 while en is high and raises
// strobe during the terminal cycle. clr forces the count back to 0 and wins over en.
module step_prescaler #(
  parameter int unsigned TERMINAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  localparam int unsigned CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Strobe comes straight from the registered count so it never depends on clr.
  assign strobe = en && (cnt_q == CW'(TERMINAL - 1));

  // Next count: clear, wrap on the terminal cycle, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || strobe) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/duty_ramp_gen.sv
// Triangle-wave duty generator for the pwm stage. Ramps pwm_value from 0 up to
// PEAK and back in STEPS increments, one increment every STEP_CYCLES clocks, and
// pulses phase_tick for one cycle at each peak and trough.
// Build macro DUTY_RAMP_HOLD_EN adds a HOLD_STEPS-step dwell after every tick.
// enable=0 beats sync, which beats normal stepping. state_dbg mirrors the FSM state.
module duty_ramp_gen
  import duty_ramp_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = 1800,
  parameter int unsigned STEPS        = 200,
  parameter int unsigned STEP_CYCLES  = 10000,
  parameter int unsigned HOLD_STEPS   = 50
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              sync,
  output logic [$clog2(PWM_INTERVAL)-1:0]   pwm_value,
  output logic                              dir_down,
  output logic                              phase_tick,
  output logic [2:0]                        state_dbg
);

  localparam int unsigned VW        = $clog2(PWM_INTERVAL);
  localparam int unsigned IW        = $clog2(STEPS + 1);
  localparam int unsigned STEP_SIZE = step_size(PWM_INTERVAL, STEPS);
  localparam int unsigned PEAK      = peak(PWM_INTERVAL, STEPS);
  localparam logic [VW-1:0] STEP_V  = VW'(STEP_SIZE);
  localparam logic [VW-1:0] PEAK_V  = VW'(PEAK);

  // Reject parameter sets the ramp cannot represent.
  if (STEPS < 2 || STEPS > PWM_INTERVAL || STEP_CYCLES < 1 || HOLD_STEPS < 1 ||
      PEAK >= (1 << VW)) begin : g_bad_params
    $error("duty_ramp_gen: unsupported parameter combination");
  end

  ramp_state_t    state_q, state_d;
  logic [VW-1:0]  pwm_q, pwm_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           tick_q, tick_d;
  logic           step_strobe;
  logic           presc_clr;
  logic           run;
  logic           restart;

  assign run     = (state_q != ST_IDLE);
  assign restart = enable && sync;
  // Any state change, a sync restart, or sitting in IDLE restarts the step period.
  assign presc_clr = (state_d != state_q) || restart || !run;

  step_prescaler #(.TERMINAL(STEP_CYCLES)) u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (run),
    .clr    (presc_clr),
    .strobe (step_strobe)
  );

`ifdef DUTY_RAMP_HOLD_EN
  logic in_hold;
  logic hold_done;

  assign in_hold = (state_q == ST_HOLD_HI) || (state_q == ST_HOLD_LO);

  // Counts step strobes while dwelling; shares the clear with the step counter.
  step_prescaler #(.TERMINAL(HOLD_STEPS)) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (step_strobe && in_hold),
    .clr    (presc_clr),
    .strobe (hold_done)
  );
`endif

  // Next-state, duty and tick computation with enable/sync priority.
  always_comb begin
    state_d = state_q;
    pwm_d   = pwm_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      pwm_d   = '0;
      idx_d   = '0;
    end else if (sync) begin
      state_d = ST_RISE;
      pwm_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RISE;
          pwm_d   = '0;
          idx_d   = '0;
        end
        ST_RISE: begin
          if (step_strobe) begin
            if (idx_q == IW'(STEPS - 1)) begin
              idx_d   = IW'(STEPS);
              pwm_d   = PEAK_V;
              tick_d  = 1'b1;
`ifdef DUTY_RAMP_HOLD_EN
              state_d = ST_HOLD_HI;
`else
              state_d = ST_FALL;
`endif
            end else begin
              idx_d = idx_q + IW'(1);
              pwm_d = pwm_q + STEP_V;
            end
          end
        end
        ST_FALL: begin
          if (step_strobe) begin
            if (idx_q == IW'(1)) begin
              idx_d   = '0;
              pwm_d   = '0;
              tick_d  = 1'b1;
`ifdef DUTY_RAMP_HOLD_EN
              state_d = ST_HOLD_LO;
`else
              state_d = ST_RISE;
`endif
            end else begin
              idx_d = idx_q - IW'(1);
              pwm_d = pwm_q - STEP_V;
            end
          end
        end
`ifdef DUTY_RAMP_HOLD_EN
        ST_HOLD_HI: begin
          if (hold_done) begin
            state_d = ST_FALL;
          end
        end
        ST_HOLD_LO: begin
          if (hold_done) begin
            state_d = ST_RISE;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          pwm_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pwm_q   <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
    end
  end

  assign pwm_value  = pwm_q;
  assign phase_tick = tick_q;
  assign dir_down   = (state_q == ST_FALL) || (state_q == ST_HOLD_HI);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_duty_ramp_gen.sv
// Directed bench for duty_ramp_gen with PWM_INTERVAL=100, STEPS=10, STEP_CYCLES=4
// (STEP_SIZE=10, PEAK=100), HOLD_STEPS=2. Honours DUTY_RAMP_HOLD_EN when defined.
module tb_duty_ramp_gen;
  import duty_ramp_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       sync;
  logic [6:0] pwm_value;
  logic       dir_down;
  logic       phase_tick;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       en;
    logic       syn;
    int         adv;
    int         pwm;
    logic       dir;
    int         ticks;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];

  duty_ramp_gen #(
    .PWM_INTERVAL (100),
    .STEPS        (10),
    .STEP_CYCLES  (4),
    .HOLD_STEPS   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sync       (sync),
    .pwm_value  (pwm_value),
    .dir_down   (dir_down),
    .phase_tick (phase_tick),
    .state_dbg  (state_dbg)
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each edge; sync is a one-cycle pulse.
  task automatic adv(input int n, output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (phase_tick) ticks++;
      sync = 1'b0;
    end
  endtask

  task automatic add(input logic en, input logic syn, input int n, input int pwm,
                     input logic dir, input int ticks, input logic [2:0] st);
    vec_t v;
    v.en = en; v.syn = syn; v.adv = n; v.pwm = pwm;
    v.dir = dir; v.ticks = ticks; v.st = st;
    tbl.push_back(v);
  endtask

  initial begin
    int tk;
    string nm;

    rst_n  = 1'b0;
    enable = 1'b0;
    sync   = 1'b0;

    // Ramp from enable rising up to the first peak (shared by both builds).
    add(1, 0, 1,   0, 0, 0, ST_RISE);
    add(1, 0, 3,   0, 0, 0, ST_RISE);
    add(1, 0, 1,  10, 0, 0, ST_RISE);
    add(1, 0, 4,  20, 0, 0, ST_RISE);
    add(1, 0, 31, 90, 0, 0, ST_RISE);
`ifdef DUTY_RAMP_HOLD_EN
    add(1, 0, 1, 100, 1, 1, ST_HOLD_HI);
    add(1, 0, 11, 100, 1, 0, ST_FALL);
    add(1, 0, 1,  90, 1, 0, ST_FALL);
    add(1, 0, 36,  0, 0, 1, ST_HOLD_LO);
    add(1, 0, 8,   0, 0, 0, ST_RISE);
    add(1, 0, 4,  10, 0, 0, ST_RISE);
    add(1, 0, 36, 100, 1, 1, ST_HOLD_HI);
    add(1, 0, 5, 100, 1, 0, ST_HOLD_HI);
    add(1, 1, 1,   0, 0, 0, ST_RISE);
    add(1, 0, 4,  10, 0, 0, ST_RISE);
    add(0, 0, 1,   0, 0, 0, ST_IDLE);
`else
    add(1, 0, 1, 100, 1, 1, ST_FALL);
    add(1, 0, 1, 100, 1, 0, ST_FALL);
    add(1, 0, 3,  90, 1, 0, ST_FALL);
    add(1, 0, 35, 10, 1, 0, ST_FALL);
    add(1, 0, 1,   0, 0, 1, ST_RISE);
    add(1, 0, 4,  10, 0, 0, ST_RISE);
    add(1, 0, 20, 60, 0, 0, ST_RISE);
    add(1, 1, 1,   0, 0, 0, ST_RISE);
    add(1, 0, 3,   0, 0, 0, ST_RISE);
    add(1, 0, 1,  10, 0, 0, ST_RISE);
    add(1, 0, 36, 100, 1, 1, ST_FALL);
    add(1, 0, 12, 70, 1, 0, ST_FALL);
    add(0, 0, 1,   0, 0, 0, ST_IDLE);
    add(0, 0, 5,   0, 0, 0, ST_IDLE);
    add(1, 0, 1,   0, 0, 0, ST_RISE);
    add(1, 0, 4,  10, 0, 0, ST_RISE);
    add(1, 0, 35, 90, 0, 0, ST_RISE);
    add(1, 1, 1,   0, 0, 0, ST_RISE);
    add(1, 0, 4,  10, 0, 0, ST_RISE);
    add(0, 1, 1,   0, 0, 0, ST_IDLE);
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm", int'(pwm_value), 0);
    check("reset_dir", int'(dir_down), 0);
    check("reset_tick", int'(phase_tick), 0);
    check("reset_state", int'(state_dbg), int'(ST_IDLE));
    rst_n = 1'b1;

    // Disabled for 20 clocks: parked at zero, no ticks.
    adv(20, tk);
    check("idle_ticks", tk, 0);
    check("idle_pwm", int'(pwm_value), 0);
    check("idle_state", int'(state_dbg), int'(ST_IDLE));

    // Table-driven ramp, sync and enable sequences.
    foreach (tbl[i]) begin
      enable = tbl[i].en;
      sync   = tbl[i].syn;
      adv(tbl[i].adv, tk);
      nm = $sformatf("row%0d", i);
      check({nm, "_pwm"}, int'(pwm_value), tbl[i].pwm);
      check({nm, "_dir"}, int'(dir_down), int'(tbl[i].dir));
      check({nm, "_ticks"}, tk, tbl[i].ticks);
      check({nm, "_state"}, int'(state_dbg), int'(tbl[i].st));
    end

    // Async reset between edges mid-ramp, then restart through IDLE.
    enable = 1'b0;
    adv(2, tk);
    enable = 1'b1;
    adv(13, tk);
    check("pre_rst_pwm", int'(pwm_value), 30);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", int'(pwm_value), 0);
    check("async_rst_dir", int'(dir_down), 0);
    check("async_rst_tick", int'(phase_tick), 0);
    check("async_rst_state", int'(state_dbg), int'(ST_IDLE));
    #1;
    rst_n = 1'b1;
    adv(1, tk);
    check("post_rst_state", int'(state_dbg), int'(ST_RISE));
    check("post_rst_pwm0", int'(pwm_value), 0);
    adv(4, tk);
    check("post_rst_pwm1", int'(pwm_value), 10);
    check("post_rst_ticks", tk, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
